// File: rtl/mem_hash_pkg.sv
// mem_hash_pkg: shared bank-state encoding and row geometry constants
package mem_hash_pkg;
  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;
  localparam int MAX_ROWS = 64;
  localparam int ROW_AW = 6;
endpackage

// File: rtl/mem_array_bank.sv
// mem_array_bank: simple dual-port row store, one write port and one registered read port
module mem_array_bank #(
  parameter int W = 1024,
  parameter int DEPTH = 64,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  // row storage, deliberately not reset
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // registered read port, cleared on reset so rd_data starts at zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/mem_array_sink.sv
// mem_array_sink: ping-pong two-bank array sink with tagged fill and random-access read
module mem_array_sink
  import mem_hash_pkg::*;
#(
  parameter int N = 32,
  parameter int ROWS = MAX_ROWS,
  parameter int ID_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [ROW_AW-1:0]   in_addr,
  input  logic [N*32-1:0]     in_data,
  input  logic [ID_WIDTH-1:0] in_index,
  output logic                in_ready,
  output logic                out_valid,
  output logic [ID_WIDTH-1:0] out_index,
  input  logic                rd_en,
  input  logic [ROW_AW-1:0]   rd_addr,
  output logic [N*32-1:0]     rd_data,
  output logic                rd_data_valid,
  input  logic                release_req,
  output logic                err
);
  localparam int AW = $clog2(ROWS);
  localparam int CW = AW + 1;
  bank_state_e st [2];
  bank_state_e st_n [2];
  logic fill_ptr, fill_ptr_n, rd_ptr, rd_ptr_n, sel;
  logic [CW-1:0] cnt, cnt_n;
  logic [ID_WIDTH-1:0] tag [2];
  logic acc, last, rel, bad, rd_go;
  logic [N*32-1:0] rdata [2];
  // bank states, pointers, fill counter, tags, sticky error and read tracking
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= '{BANK_EMPTY, BANK_EMPTY};
      fill_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt <= '0;
      tag <= '{default: '0};
      err <= 1'b0;
      rd_data_valid <= 1'b0;
      sel <= 1'b0;
    end else begin
      st <= st_n;
      fill_ptr <= fill_ptr_n;
      rd_ptr <= rd_ptr_n;
      cnt <= cnt_n;
      if (acc && st[fill_ptr] == BANK_EMPTY) tag[fill_ptr] <= in_index;
      err <= err | bad;
      rd_data_valid <= rd_go;
      if (rd_go) sel <= rd_ptr;
    end
  // next state: a release and a last-row accept can land in the same cycle on different banks
  always_comb begin
    acc = in_valid && in_ready;
    last = acc && cnt == CW'(ROWS - 1);
    rel = release_req && out_valid;
    rd_go = rd_en && out_valid;
    bad = acc && (in_addr != ROW_AW'(cnt) || (st[fill_ptr] != BANK_EMPTY && in_index != tag[fill_ptr]));
    cnt_n = last ? '0 : acc ? cnt + CW'(1) : cnt;
    fill_ptr_n = last ? ~fill_ptr : fill_ptr;
    rd_ptr_n = rel ? ~rd_ptr : rd_ptr;
    for (int b = 0; b < 2; b++)
      st_n[b] = (rel && rd_ptr == 1'(b)) ? BANK_EMPTY :
                (acc && fill_ptr == 1'(b)) ? (last ? BANK_FULL : BANK_FILLING) : st[b];
  end
  // outputs: read data comes from the bank that was the read bank when the request was made
  always_comb begin
    in_ready = st[fill_ptr] != BANK_FULL;
    out_valid = st[rd_ptr] == BANK_FULL;
    out_index = tag[rd_ptr];
    rd_data = rdata[sel];
  end
  for (genvar g = 0; g < 2; g++) begin : g_bank
    mem_array_bank #(.W(N * 32), .DEPTH(ROWS), .AW(AW)) u_bank (
      .clk(clk),
      .rst_n(rst_n),
      .we(acc && fill_ptr == 1'(g)),
      .waddr(in_addr[AW-1:0]),
      .wdata(in_data),
      .re(rd_go && rd_ptr == 1'(g)),
      .raddr(rd_addr[AW-1:0]),
      .rdata(rdata[g])
    );
  end
endmodule

// File: doc/mem_array_sink.md
MEM_ARRAY_SINK -- requirements
Module: mem_array_sink

Interface
REQ-001 SHALL have parameter N, default 32, words of 32 bits per row.
REQ-002 SHALL have parameter ROWS, default 64, rows per array; power of two, at most 64.
REQ-003 SHALL have parameter ID_WIDTH, default 32, width of the array index tag.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  row present from the generator.
REQ-007 in_addr  input  6  row address, 0..ROWS-1.
REQ-008 in_data  input  N*32  row payload.
REQ-009 in_index  input  ID_WIDTH  array tag of the row.
REQ-010 in_ready  output  1  sink accepts a row this cycle; drives the generator's downstream-ready input.
REQ-011 out_valid  output  1  a complete array is readable.
REQ-012 out_index  output  ID_WIDTH  tag of the readable array.
REQ-013 rd_en  input  1  read request; ignored unless out_valid.
REQ-014 rd_addr  input  6  row to read.
REQ-015 rd_data  output  N*32  read row data.
REQ-016 rd_data_valid  output  1  rd_data is valid this cycle.
REQ-017 release  input  1  consumer is done with the readable array; ignored unless out_valid.
REQ-018 err  output  1  sticky protocol error flag.

Function
REQ-019 SHALL hold two banks (ping-pong), each ROWS x N*32, with one fill bank and one read bank.
- Per-bank state: EMPTY -> FILLING (first row accepted) -> FULL (row ROWS-1 accepted) -> EMPTY (release).
REQ-020 in_ready SHALL be 1 iff the current fill bank is EMPTY or FILLING.
REQ-021 A row SHALL be accepted when in_valid and in_ready are both 1 in the same cycle; the row is written at in_addr.
REQ-022 The fill-row counter SHALL be log2(ROWS)+1 bits wide, increment on each accept, and clear when the bank turns FULL.
REQ-023 The first accepted row of a bank SHALL latch in_index as the bank tag.
REQ-024 Rows SHALL arrive in order 0..ROWS-1.
- If in_addr does not equal the counter, or in_index does not equal the latched tag on a non-first row: set err and still write the row at in_addr.
REQ-025 On the cycle the last row is accepted, the bank SHALL become FULL and the fill pointer SHALL toggle to the other bank.
- in_ready on the following cycle reflects the new fill bank's state.
REQ-026 out_valid SHALL be 1 iff the read bank is FULL; out_index SHALL equal that bank's tag.
REQ-027 rd_data SHALL return the row at rd_addr with 1-cycle latency; rd_data_valid SHALL be rd_en delayed by one cycle, gated by out_valid at request time.
REQ-028 release SHALL set the read bank to EMPTY and toggle the read pointer; out_valid SHALL drop on the next cycle unless the other bank is already FULL.
REQ-029 Simultaneous release and accept of a last row into the other bank: both take effect; out_valid stays 1 with the new tag next cycle.
REQ-030 Both banks FULL: in_ready=0 until a release.
- The generator stalls, since its clock enable requires ready or !valid.
REQ-031 Simultaneous rd_en and release: the read completes with the pre-release data.
REQ-032 err SHALL clear only on reset.

Reset
REQ-033 On rst_n low, asynchronously:
- both banks EMPTY, both pointers 0, counter 0
- in_ready=1, out_valid=0, rd_data_valid=0, err=0, out_index=0, rd_data=0
REQ-034 Memory contents SHALL NOT be reset.
- Reset mid-fill discards the partial array; the generator's reset aligns the two sides.

Structure
REQ-035 Bank-state encoding (EMPTY/FILLING/FULL) and the ROWS/row-address-width constants SHALL live in the shared mem_hash package.
REQ-036 Each bank SHALL be a sub-module, mem_array_bank: simple dual-port, one write port and one registered read port, instantiated twice.

Verification
REQ-037 N=2, ROWS=4: rows 0..3 with tag 0x11 and data = addr*0x01010101 -> out_valid=1 one cycle after row 3, out_index=0x11; rd_addr 2 -> rd_data=0x0202020202020202 one cycle later.
REQ-038 Fill bank A (tag 1), then bank B (tag 2) with no release -> in_ready=0 after B's last row; a row offered with in_valid=1 is not accepted; release -> out_index=2, in_ready=1.
REQ-039 Rows sent in order 0,2,1,3 -> err=1 and stays 1 after release; out_valid still asserts after 4 rows.
REQ-040 Release in the same cycle as bank B's last row -> out_valid stays 1 and out_index changes from A's tag to B's tag next cycle.
REQ-041 rst_n low after 2 rows, then high -> in_ready=1, out_valid=0, err=0; a fresh 4-row fill completes normally.
REQ-042 Connect to the generator with random release delays of 0..10 cycles over 8 arrays -> tags arrive in order with no lost or duplicated rows.
